light_mode_ctrl: RTL and testbench
==================================

LIGHT_MODE_CTRL -- requirements
Module: light_mode_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 16: consecutive identical synchronized samples required to accept a switch value; legal range 2..65535.
REQ-002 Parameter TICK_DIV, default 12500000: Clock cycles per step period; legal range 2..2^32-1.
REQ-003 Clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-low reset (asserted when 0, sampled on the Clock rising edge).
REQ-005 SW  input  2  raw, asynchronous, bouncing mode switches.
REQ-006 Enable  input  1  when 1, the step timebase runs; when 0, it holds.
REQ-007 mode  output  2  debounced, registered mode code, driven to the downstream light pattern FSM.
REQ-008 step  output  1  one-cycle pulse that advances the downstream pattern.
REQ-009 restart  output  1  one-cycle pulse on every accepted mode change; the downstream FSM reloads its start pattern.
REQ-010 stable  output  1  1 when state is RUN, else 0.

Function
REQ-011 SW shall pass through a 2-flop synchronizer (sw_s1 then sw_s2); only sw_s2 feeds logic.
REQ-012 The state machine shall have states INIT, RUN and CHANGE; internal registers are cand[1:0], deb_cnt[15:0] and tick_cnt[31:0].
REQ-013 INIT: if sw_s2==cand, deb_cnt increments; else cand<=sw_s2 and deb_cnt<=1.
REQ-014 INIT commit: when sw_s2==cand and deb_cnt==DEB_CYCLES-1, then mode<=cand, restart=1 for that cycle, tick_cnt<=0, and the state goes to RUN.
REQ-015 INIT: step=0; tick_cnt held at 0.
REQ-016 RUN: if sw_s2!=mode, then the state goes to CHANGE, cand<=sw_s2 and deb_cnt<=1.
REQ-017 CHANGE, sw_s2==cand: deb_cnt increments; at deb_cnt==DEB_CYCLES-1 commit as in REQ-014 (mode<=cand, restart pulse, tick_cnt<=0, go to RUN).
REQ-018 CHANGE, sw_s2==mode: return to RUN; mode unchanged; no restart (glitch rejected).
REQ-019 CHANGE, sw_s2 differs from both cand and mode: cand<=sw_s2, deb_cnt<=1; stay in CHANGE.
REQ-020 Latency: a raw SW change held stable shall appear on mode after exactly DEB_CYCLES+2 rising edges.
REQ-021 Timebase in RUN and CHANGE with Enable=1: tick_cnt increments each cycle.
REQ-022 Timebase wrap: when tick_cnt==TICK_DIV-1, then tick_cnt<=0 and step=1 for that cycle.
REQ-023 Enable=0: tick_cnt holds and step=0; restart and debounce are unaffected.
REQ-024 Commit and tick terminal count in the same cycle: commit wins; step=0; tick_cnt<=0.
REQ-025 step and restart shall never be 1 in the same cycle.
REQ-026 step and restart shall never exceed one cycle wide.
REQ-027 Mode code meanings are passed through unchanged: 00 centre/ends alternate, 01 right-to-left, 10 left-to-right, 11 hold.
REQ-028 Arithmetic: all counters are unsigned; deb_cnt saturates at DEB_CYCLES-1; tick_cnt never exceeds TICK_DIV-1.

Reset
REQ-029 Reset=0 at a rising edge: state<=INIT, mode<=00, step<=0, restart<=0, stable<=0, cand<=00, deb_cnt<=0, tick_cnt<=0, sw_s1<=00, sw_s2<=00.
REQ-030 Reset takes effect from any state, including mid-debounce, and discards the pending candidate.
REQ-031 After Reset returns to 1, the first commit requires DEB_CYCLES consecutive matching samples.

Verification (DEB_CYCLES=4, TICK_DIV=5)
REQ-032 Power-up: Reset=0 for 2 cycles, then 1 with SW=01, Enable=1. Required response:
- mode=01, restart pulses once, stable rises; step stays 0 until that point.
REQ-033 Timebase in RUN, Enable=1, SW constant. Required response:
- step pulses every 5th cycle, exactly 1 cycle wide.
- Enable=0 for 7 cycles yields no step, and the count resumes where it held.
REQ-034 Bounce: in RUN with mode=01, SW toggles 01->10->01 with 2 cycles per value. Required response:
- mode stays 01, no restart, stable dips low then returns to 1.
REQ-035 Clean change: SW 01->10 held. Required response:
- mode=10 exactly 6 edges later, restart one cycle, tick_cnt=0.
- The next step occurs 5 cycles after restart.
REQ-036 Collision: change timed so the commit lands on tick_cnt==4. Required response:
- restart=1 and step=0 in that cycle.
REQ-037 Reset mid-debounce: Reset=0 while in CHANGE with deb_cnt=2. Required response:
- next cycle mode=00, stable=0, restart=0.
- The old candidate is never committed unless it is re-held for a full DEB_CYCLES after Reset returns to 1.

Source files
------------

// File: rtl/light_mode_ctrl.sv
// light_mode_ctrl: debounces a 2-bit mode switch, publishes the accepted mode
// to a downstream light-pattern FSM, and generates the pattern step timebase.
// A new mode is committed only after DEB_CYCLES identical synchronized samples.
// A commit raises a one-cycle restart pulse and realigns the step timebase.
module light_mode_ctrl #(
    parameter int unsigned DEB_CYCLES = 32'd16,
    parameter int unsigned TICK_DIV   = 32'd12500000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] sw_i,
    input  logic       enable_i,
    output logic [1:0] mode_o,
    output logic       step_o,
    output logic       restart_o,
    output logic       stable_o
);

    localparam logic [15:0] DEB_LAST  = 16'(DEB_CYCLES - 32'd1);
    localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 32'd1);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_CHANGE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  sw_s1_q, sw_s2_q;
    logic [1:0]  mode_q, mode_d;
    logic [1:0]  cand_q, cand_d;
    logic [15:0] deb_cnt_q, deb_cnt_d;
    logic [31:0] tick_cnt_q, tick_cnt_d;
    logic        step_q, step_d;
    logic        restart_q, restart_d;
    logic        stable_q, stable_d;
    logic        commit_s;

    // Two-flop synchronizer for the asynchronous, bouncing switch inputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sw_s1_q <= 2'b00;
            sw_s2_q <= 2'b00;
        end else begin
            sw_s1_q <= sw_i;
            sw_s2_q <= sw_s1_q;
        end
    end

    // Next-state logic: debounce FSM, timebase, and registered output values.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        cand_d     = cand_q;
        deb_cnt_d  = deb_cnt_q;
        tick_cnt_d = tick_cnt_q;
        step_d     = 1'b0;
        restart_d  = 1'b0;
        commit_s   = 1'b0;

        case (state_q)
            ST_INIT: begin
                if (sw_s2_q == cand_q) begin
                    if (deb_cnt_q == DEB_LAST) begin
                        commit_s = 1'b1;
                    end else begin
                        deb_cnt_d = deb_cnt_q + 16'd1;
                    end
                end else begin
                    cand_d    = sw_s2_q;
                    deb_cnt_d = 16'd1;
                end
            end
            ST_RUN: begin
                if (sw_s2_q != mode_q) begin
                    state_d   = ST_CHANGE;
                    cand_d    = sw_s2_q;
                    deb_cnt_d = 16'd1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_CHANGE: begin
                if (sw_s2_q == cand_q) begin
                    if (deb_cnt_q == DEB_LAST) begin
                        commit_s = 1'b1;
                    end else begin
                        deb_cnt_d = deb_cnt_q + 16'd1;
                    end
                end else if (sw_s2_q == mode_q) begin
                    // Glitch rejected: the switch came back to the accepted mode.
                    state_d = ST_RUN;
                end else begin
                    cand_d    = sw_s2_q;
                    deb_cnt_d = 16'd1;
                end
            end
            default: begin
                state_d    = ST_INIT;
                cand_d     = 2'b00;
                deb_cnt_d  = 16'd0;
                tick_cnt_d = 32'd0;
            end
        endcase

        // Step timebase runs only once a mode has been accepted.
        if ((state_q == ST_RUN || state_q == ST_CHANGE) && enable_i) begin
            if (tick_cnt_q == TICK_LAST) begin
                tick_cnt_d = 32'd0;
                step_d     = 1'b1;
            end else begin
                tick_cnt_d = tick_cnt_q + 32'd1;
            end
        end else begin
            step_d = 1'b0;
        end

        // A commit overrides any coincident step and realigns the timebase.
        if (commit_s) begin
            mode_d     = cand_q;
            restart_d  = 1'b1;
            step_d     = 1'b0;
            tick_cnt_d = 32'd0;
            state_d    = ST_RUN;
        end else begin
            restart_d = 1'b0;
        end

        stable_d = (state_d == ST_RUN);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_INIT;
            mode_q     <= 2'b00;
            cand_q     <= 2'b00;
            deb_cnt_q  <= 16'd0;
            tick_cnt_q <= 32'd0;
            step_q     <= 1'b0;
            restart_q  <= 1'b0;
            stable_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            cand_q     <= cand_d;
            deb_cnt_q  <= deb_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            step_q     <= step_d;
            restart_q  <= restart_d;
            stable_q   <= stable_d;
        end
    end

    assign mode_o    = mode_q;
    assign step_o    = step_q;
    assign restart_o = restart_q;
    assign stable_o  = stable_q;

endmodule

// File: tb/tb_light_mode_ctrl.sv
// Directed testbench for light_mode_ctrl with DEB_CYCLES=4, TICK_DIV=5.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_light_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] sw;
    logic       enable;
    logic [1:0] mode;
    logic       step;
    logic       restart;
    logic       stable;

    int tests = 0;
    int fails = 0;

    light_mode_ctrl #(
        .DEB_CYCLES(32'd4),
        .TICK_DIV  (32'd5)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .sw_i     (sw),
        .enable_i (enable),
        .mode_o   (mode),
        .step_o   (step),
        .restart_o(restart),
        .stable_o (stable)
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] m, input logic st,
                           input logic rs, input logic sb);
        chk({tag, ".mode"},    {30'd0, mode},    {30'd0, m});
        chk({tag, ".step"},    {31'd0, step},    {31'd0, st});
        chk({tag, ".restart"}, {31'd0, restart}, {31'd0, rs});
        chk({tag, ".stable"},  {31'd0, stable},  {31'd0, sb});
    endtask

    initial begin
        // Power-up: reset for two edges with SW=01 and Enable=1.
        rst_n  = 1'b0;
        sw     = 2'b01;
        enable = 1'b1;
        edge1();
        edge1();
        chk_all("reset", 2'b00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        // Edges 1..5: still debouncing; commit on edge 6.
        for (int i = 1; i <= 5; i++) begin
            edge1();
            chk_all($sformatf("pu%0d", i), 2'b00, 1'b0, 1'b0, 1'b0);
        end
        edge1();
        chk_all("pu_commit", 2'b01, 1'b0, 1'b1, 1'b1);

        // Timebase: step on every 5th edge after the commit.
        for (int k = 1; k <= 15; k++) begin
            edge1();
            chk_all($sformatf("tb%0d", k), 2'b01, ((k % 5) == 0), 1'b0, 1'b1);
        end
        // Advance to tick_cnt=2, then hold for 7 edges.
        edge1();
        edge1();
        chk("pre_hold.step", {31'd0, step}, 32'd0);
        enable = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            edge1();
            chk($sformatf("hold%0d.step", k), {31'd0, step}, 32'd0);
        end
        enable = 1'b1;
        edge1();
        chk("resume1.step", {31'd0, step}, 32'd0);
        edge1();
        chk("resume2.step", {31'd0, step}, 32'd0);
        edge1();
        chk("resume3.step", {31'd0, step}, 32'd1);

        // Bounce: 01 -> 10 -> 01, two cycles per value; tick_cnt starts at 0.
        sw = 2'b10;
        edge1();
        chk_all("bn1", 2'b01, 1'b0, 1'b0, 1'b1);
        edge1();
        chk_all("bn2", 2'b01, 1'b0, 1'b0, 1'b1);
        sw = 2'b01;
        edge1();
        chk_all("bn3", 2'b01, 1'b0, 1'b0, 1'b0);
        edge1();
        chk_all("bn4", 2'b01, 1'b0, 1'b0, 1'b0);
        edge1();
        chk_all("bn5", 2'b01, 1'b1, 1'b0, 1'b1);

        // Clean change 01 -> 10; tick_cnt starts at 0.
        sw = 2'b10;
        edge1();
        chk_all("cc1", 2'b01, 1'b0, 1'b0, 1'b1);
        edge1();
        chk_all("cc2", 2'b01, 1'b0, 1'b0, 1'b1);
        edge1();
        chk_all("cc3", 2'b01, 1'b0, 1'b0, 1'b0);
        edge1();
        chk_all("cc4", 2'b01, 1'b0, 1'b0, 1'b0);
        edge1();
        chk_all("cc5", 2'b01, 1'b1, 1'b0, 1'b0);
        edge1();
        chk_all("cc6", 2'b10, 1'b0, 1'b1, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            edge1();
            chk_all($sformatf("cc_post%0d", k), 2'b10, 1'b0, 1'b0, 1'b1);
        end
        // Start the collision change one edge before the next step.
        sw = 2'b11;
        edge1();
        chk_all("cc_post5", 2'b10, 1'b1, 1'b0, 1'b1);

        // Collision: commit lands when tick_cnt==4.
        for (int k = 2; k <= 5; k++) begin
            edge1();
            chk($sformatf("col%0d.restart", k), {31'd0, restart}, 32'd0);
            chk($sformatf("col%0d.step", k), {31'd0, step}, 32'd0);
        end
        edge1();
        chk_all("col_commit", 2'b11, 1'b0, 1'b1, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            edge1();
            chk($sformatf("col_post%0d.step", k), {31'd0, step}, 32'd0);
        end
        edge1();
        chk("col_post5.step", {31'd0, step}, 32'd1);

        // Reset mid-debounce: candidate 10 reaches deb_cnt=2, then reset.
        sw = 2'b10;
        for (int k = 1; k <= 4; k++) begin
            edge1();
            chk($sformatf("rd%0d.mode", k), {30'd0, mode}, 32'd3);
        end
        rst_n = 1'b0;
        edge1();
        chk_all("rd_reset", 2'b00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            edge1();
            chk_all($sformatf("rr%0d", k), 2'b00, 1'b0, 1'b0, 1'b0);
        end
        edge1();
        chk_all("rr_commit", 2'b10, 1'b0, 1'b1, 1'b1);
        edge1();
        chk_all("rr_after", 2'b10, 1'b0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
